// File: rtl/lif_pkg.sv
// Shared types for the LIF spike-rate monitor: FSM states, default widths
// and the default-width result record.
package lif_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      HOLD  = 2'd2
   } state_t;

   localparam int CNT_W_DEF = 8;
   localparam int WIN_W_DEF = 16;

   typedef struct packed {
      logic [CNT_W_DEF-1:0] count;
      logic [WIN_W_DEF-1:0] isi_min;
      logic                 overflow;
   } result_t;

endpackage

// File: rtl/lif_isi_tracker.sv
// Minimum inter-spike interval tracker. isi_min already folds in a spike seen
// this cycle, so the window-end result can be captured without a bubble.
module lif_isi_tracker #(
   parameter int WIN_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             spike,
   output logic [WIN_W-1:0] isi_min
);

   localparam logic [WIN_W-1:0] ONES = '1;

   logic             seen;
   logic [WIN_W-1:0] elapsed;
   logic [WIN_W-1:0] min_q;

   function automatic logic [WIN_W-1:0] sat_inc(input logic [WIN_W-1:0] v);
      return (v == ONES) ? v : v + 1'b1;
   endfunction

   always_comb begin
      isi_min = min_q;
      if (spike && seen && (elapsed < min_q)) isi_min = elapsed;
   end

   // elapsed counts cycles since the previous spike, so at a spike it equals the ISI
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         seen    <= 1'b0;
         elapsed <= '0;
         min_q   <= ONES;
      end else if (clr) begin
         seen    <= 1'b0;
         elapsed <= '0;
         min_q   <= ONES;
      end else begin
         min_q <= isi_min;
         if (spike) begin
            seen    <= 1'b1;
            elapsed <= WIN_W'(1);
         end else begin
            elapsed <= sat_inc(elapsed);
         end
      end
   end

endmodule

// File: rtl/lif_spike_rate_monitor.sv
// Spike-rate monitor: counts spikes per programmable window, tracks the
// minimum ISI and reports each window through a 2-entry valid/ready buffer.
module lif_spike_rate_monitor
   import lif_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF,
   parameter int WIN_W = WIN_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             spike,
   input  logic [WIN_W-1:0] win_len,
   output logic             rate_valid,
   input  logic             rate_ready,
   output logic [CNT_W-1:0] rate_count,
   output logic [WIN_W-1:0] isi_min,
   output logic             overflow,
   output logic             miss,
   output logic             busy
);

   typedef struct packed {
      logic [CNT_W-1:0] count;
      logic [WIN_W-1:0] isi_min;
      logic             overflow;
   } res_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           state, state_nxt;
   logic [WIN_W-1:0] last_q;
   logic [WIN_W-1:0] cyc;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             sat, sat_nxt;
   logic [WIN_W-1:0] trk_isi;
   res_t             out_q, sh_q, res_now;
   logic             out_vld;
   logic             hs, win_end;
   logic             load_win, load_out, load_sh, shift_sh;

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c, input logic s);
      return (s && (c != CNT_MAX)) ? c + 1'b1 : c;
   endfunction

   assign hs      = out_vld & rate_ready;
   assign win_end = (state == COUNT) && (cyc == last_q);
   assign cnt_nxt = sat_add(cnt, spike);
   assign sat_nxt = sat | (spike & (cnt == CNT_MAX));
   assign res_now = '{count: cnt_nxt, isi_min: trk_isi, overflow: sat_nxt};

   lif_isi_tracker #(.WIN_W(WIN_W)) u_isi (
      .clk     (clk),
      .rst     (rst),
      .clr     ((state != COUNT) || win_end),
      .spike   (spike && (state == COUNT)),
      .isi_min (trk_isi)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      load_win  = 1'b0;
      load_out  = 1'b0;
      load_sh   = 1'b0;
      shift_sh  = 1'b0;
      case (state)
         IDLE: begin
            if (en) begin
               state_nxt = COUNT;
               load_win  = 1'b1;
            end
         end
         COUNT: begin
            // a finished window is always reported; en only decides what follows
            if (win_end) begin
               if (!out_vld || hs) begin
                  load_out = 1'b1;
                  if (en) load_win  = 1'b1;
                  else    state_nxt = IDLE;
               end else begin
                  load_sh   = 1'b1;
                  state_nxt = HOLD;
               end
            end else if (!en) begin
               state_nxt = IDLE;
            end
         end
         HOLD: begin
            if (hs) begin
               shift_sh = 1'b1;
               if (en) begin
                  state_nxt = COUNT;
                  load_win  = 1'b1;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_q  <= '0;
         cyc     <= '0;
         cnt     <= '0;
         sat     <= 1'b0;
         out_q   <= '0;
         sh_q    <= '0;
         out_vld <= 1'b0;
         miss    <= 1'b0;
      end else begin
         // a zero window length behaves as a one-cycle window
         if (load_win) begin
            last_q <= (win_len == '0) ? '0 : win_len - 1'b1;
            cyc    <= '0;
            cnt    <= '0;
            sat    <= 1'b0;
         end else if (state == COUNT) begin
            cyc <= cyc + 1'b1;
            cnt <= cnt_nxt;
            sat <= sat_nxt;
         end

         if (load_out) begin
            out_q   <= res_now;
            out_vld <= 1'b1;
         end else if (shift_sh) begin
            out_q   <= sh_q;
         end else if (hs) begin
            out_vld <= 1'b0;
         end

         if (load_sh) sh_q <= res_now;
         if ((state == HOLD) && spike) miss <= 1'b1;
      end
   end

   assign rate_valid = out_vld;
   assign rate_count = out_q.count;
   assign isi_min    = out_q.isi_min;
   assign overflow   = out_q.overflow;
   assign busy       = (state != IDLE);

endmodule
